// File: rtl/motion_comparator_p.sv
// motion_comparator_p: keeps the minimum distortion and its motion vector across a search window.
// Define COMP_ZERO_BIAS_EN to break distortion ties toward the smaller |x|+|y|.
module motion_comparator_p #(
   parameter int NUM_PE = 16,
   parameter int DIST_W = 8,
   parameter int VEC_W  = 4,
   parameter int CNT_W  = 10
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       comp_start,
   input  logic [CNT_W-1:0]           search_len,
   input  logic [NUM_PE*DIST_W-1:0]   pe_out,
   input  logic [NUM_PE-1:0]          pe_ready,
   input  logic [NUM_PE*VEC_W-1:0]    vector_x,
   input  logic [NUM_PE*VEC_W-1:0]    vector_y,
   output logic [DIST_W-1:0]          best_dist,
   output logic [VEC_W-1:0]           motion_x,
   output logic [VEC_W-1:0]           motion_y,
   output logic [$clog2(NUM_PE)-1:0]  best_pe,
   output logic [CNT_W-1:0]           cand_count,
   output logic                       busy,
   output logic                       done,
   output logic                       result_valid
);
   localparam int PE_W  = $clog2(NUM_PE);
   localparam int SUM_W = CNT_W + PE_W + 1;
`ifdef COMP_ZERO_BIAS_EN
   localparam bit BIAS = 1'b1;
`else
   localparam bit BIAS = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
   state_t            state_q;
   logic [CNT_W-1:0]  len_q, cnt_q, cnt_d;
   logic [DIST_W-1:0] best_q, win_dist;
   logic [VEC_W-1:0]  mx_q, my_q, win_x, win_y;
   logic [PE_W-1:0]   pe_q, win_pe;
   logic [VEC_W:0]    win_mag, lane_mag;
   logic [PE_W:0]     pop;
   logic [SUM_W-1:0]  sum;
   logic              busy_q, done_q, valid_q, any, upd, fin;

   function automatic logic [VEC_W:0] mag(input logic [VEC_W-1:0] x, input logic [VEC_W-1:0] y);
      logic [VEC_W:0] sx, sy;
      sx = {x[VEC_W-1], x};
      sy = {y[VEC_W-1], y};
      return (x[VEC_W-1] ? -sx : sx) + (y[VEC_W-1] ? -sy : sy);
   endfunction

   function automatic logic better(input logic [DIST_W-1:0] a, input logic [VEC_W:0] am,
                                   input logic [DIST_W-1:0] b, input logic [VEC_W:0] bm);
      return a < b || (BIAS && a == b && am < bm);
   endfunction

   // strict compare while scanning upward keeps the lowest lane on ties
   always_comb begin
      win_dist = '1;
      win_x    = '0;
      win_y    = '0;
      win_mag  = '0;
      win_pe   = '0;
      lane_mag = '0;
      any      = 1'b0;
      pop      = '0;
      for (int i = 0; i < NUM_PE; i++) begin
         lane_mag = mag(vector_x[i*VEC_W +: VEC_W], vector_y[i*VEC_W +: VEC_W]);
         if (pe_ready[i] && (!any || better(pe_out[i*DIST_W +: DIST_W], lane_mag, win_dist, win_mag))) begin
            win_dist = pe_out[i*DIST_W +: DIST_W];
            win_x    = vector_x[i*VEC_W +: VEC_W];
            win_y    = vector_y[i*VEC_W +: VEC_W];
            win_mag  = lane_mag;
            win_pe   = PE_W'(i);
         end
         any = any | pe_ready[i];
         pop = pop + (PE_W+1)'(pe_ready[i]);
      end
   end

   assign sum   = SUM_W'(cnt_q) + SUM_W'(pop);
   assign cnt_d = sum > SUM_W'({CNT_W{1'b1}}) ? '1 : sum[CNT_W-1:0];
   assign upd   = any && better(win_dist, win_mag, best_q, mag(mx_q, my_q));
   assign fin   = sum >= SUM_W'(len_q);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         best_q  <= '1;
         mx_q    <= '0;
         my_q    <= '0;
         pe_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (comp_start) begin
               state_q <= SEARCH;
               len_q   <= search_len;
               cnt_q   <= '0;
               best_q  <= '1;
               mx_q    <= '0;
               my_q    <= '0;
               pe_q    <= '0;
               busy_q  <= 1'b1;
            end
            SEARCH: if (!comp_start) begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end else begin
               if (len_q != '0) begin
                  cnt_q <= cnt_d;
                  if (upd) begin
                     best_q <= win_dist;
                     mx_q   <= win_x;
                     my_q   <= win_y;
                     pe_q   <= win_pe;
                  end
               end
               if (fin) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  valid_q <= 1'b1;
               end
            end
            DONE: if (!comp_start) begin
               state_q <= IDLE;
               valid_q <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign best_dist    = best_q;
   assign motion_x     = mx_q;
   assign motion_y     = my_q;
   assign best_pe      = pe_q;
   assign cand_count   = cnt_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign result_valid = valid_q;
endmodule

// File: tb/tb_motion_comparator_p.sv
// tb_motion_comparator_p: directed vector table, hand-written corner sequences and a random
// search run checked against a candidate-list reference model.
module tb_motion_comparator_p;
   localparam int NP = 16, DW = 8, VW = 4, CW = 10;
`ifdef COMP_ZERO_BIAS_EN
   localparam bit BIAS = 1'b1;
`else
   localparam bit BIAS = 1'b0;
`endif
   logic clock = 1'b0, reset_n = 1'b0, comp_start = 1'b0;
   logic [CW-1:0]    search_len = '0;
   logic [NP*DW-1:0] pe_out = '0;
   logic [NP-1:0]    pe_ready = '0;
   logic [NP*VW-1:0] vector_x = '0, vector_y = '0;
   logic [DW-1:0]    best_dist;
   logic [VW-1:0]    motion_x, motion_y;
   logic [3:0]       best_pe;
   logic [CW-1:0]    cand_count;
   logic             busy, done, result_valid;
   int total = 0, bad = 0;

   motion_comparator_p dut (
      .clock(clock), .reset_n(reset_n), .comp_start(comp_start), .search_len(search_len),
      .pe_out(pe_out), .pe_ready(pe_ready), .vector_x(vector_x), .vector_y(vector_y),
      .best_dist(best_dist), .motion_x(motion_x), .motion_y(motion_y), .best_pe(best_pe),
      .cand_count(cand_count), .busy(busy), .done(done), .result_valid(result_valid));

   always #5 clock = ~clock;

   typedef struct {
      logic start; logic [CW-1:0] len; logic [NP-1:0] rdy;
      logic [DW-1:0] da, db; int pb;
      logic [DW-1:0] e_best; logic [3:0] e_pe; logic [CW-1:0] e_cnt;
      logic e_busy, e_done, e_rv;
   } vec_t;

   typedef struct { int d; int pe; logic [VW-1:0] x, y; int m; } cand_t;

   function automatic vec_t mk(input logic st, input int ln, input logic [NP-1:0] rd, input int da, input int db,
                               input int pb, input int eb, input int epe, input int ec,
                               input logic ebu, input logic edn, input logic erv);
      vec_t v;
      v.start = st; v.len = CW'(ln); v.rdy = rd; v.da = DW'(da); v.db = DW'(db); v.pb = pb;
      v.e_best = DW'(eb); v.e_pe = 4'(epe); v.e_cnt = CW'(ec);
      v.e_busy = ebu; v.e_done = edn; v.e_rv = erv;
      return v;
   endfunction

   function automatic int mg(input logic [VW-1:0] v);
      int s;
      s = int'($signed(v));
      return s < 0 ? -s : s;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string t, input int eb, input int epe, input logic [VW-1:0] ex, input logic [VW-1:0] ey,
                          input int ec, input logic ebu, input logic edn, input logic erv);
      chk({t, ".best_dist"}, 32'(best_dist), 32'(eb));
      chk({t, ".best_pe"}, 32'(best_pe), 32'(epe));
      chk({t, ".motion_x"}, 32'(motion_x), 32'(ex));
      chk({t, ".motion_y"}, 32'(motion_y), 32'(ey));
      chk({t, ".cand_count"}, 32'(cand_count), 32'(ec));
      chk({t, ".busy"}, 32'(busy), 32'(ebu));
      chk({t, ".done"}, 32'(done), 32'(edn));
      chk({t, ".result_valid"}, 32'(result_valid), 32'(erv));
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_lane(input int l, input int d, input logic [VW-1:0] x, input logic [VW-1:0] y);
      pe_out[l*DW +: DW]   = DW'(d);
      vector_x[l*VW +: VW] = x;
      vector_y[l*VW +: VW] = y;
   endtask

   task automatic randomize_lanes();
      pe_ready = NP'($urandom & $urandom);
      for (int l = 0; l < NP; l++) set_lane(l, $urandom_range(0, 31), VW'($urandom), VW'($urandom));
   endtask

   vec_t tv[19];
   cand_t q[$];
   cand_t b;
   int cnt, len, cyc;
   logic fin;

   initial begin
      tv[0]  = mk(1, 4, 16'h0000,  0, 0, -1, 'hFF, 0, 0, 1, 0, 0);
      tv[1]  = mk(1, 4, 16'h0001, 40, 0, -1, 40, 0, 1, 1, 0, 0);
      tv[2]  = mk(1, 4, 16'h0008, 25, 0, -1, 25, 3, 2, 1, 0, 0);
      tv[3]  = mk(1, 4, 16'h0080, 30, 0, -1, 25, 3, 3, 1, 0, 0);
      tv[4]  = mk(1, 4, 16'h8000, 25, 0, -1, 25, 3, 4, 0, 1, 1);
      tv[5]  = mk(1, 4, 16'h0000,  0, 0, -1, 25, 3, 4, 0, 0, 1);
      tv[6]  = mk(1, 4, 16'hFFFF,  0, 0, -1, 25, 3, 4, 0, 0, 1);
      tv[7]  = mk(0, 4, 16'h0000,  0, 0, -1, 25, 3, 4, 0, 0, 0);
      tv[8]  = mk(1, 2, 16'h0000,  0, 0, -1, 'hFF, 0, 0, 1, 0, 0);
      tv[9]  = mk(1, 2, 16'h0009, 12, 9,  3, 9, 3, 2, 0, 1, 1);
      tv[10] = mk(0, 2, 16'h0000,  0, 0, -1, 9, 3, 2, 0, 0, 0);
      tv[11] = mk(1, 8, 16'h0000,  0, 0, -1, 'hFF, 0, 0, 1, 0, 0);
      tv[12] = mk(1, 8, 16'h0002, 50, 0, -1, 50, 1, 1, 1, 0, 0);
      tv[13] = mk(1, 8, 16'h0004, 60, 0, -1, 50, 1, 2, 1, 0, 0);
      tv[14] = mk(1, 8, 16'h0010, 45, 0, -1, 45, 4, 3, 1, 0, 0);
      tv[15] = mk(0, 8, 16'h0000,  0, 0, -1, 45, 4, 3, 0, 0, 0);
      tv[16] = mk(1, 0, 16'h0000,  0, 0, -1, 'hFF, 0, 0, 1, 0, 0);
      tv[17] = mk(1, 0, 16'hFFFF,  0, 0, -1, 'hFF, 0, 0, 0, 1, 1);
      tv[18] = mk(0, 0, 16'h0000,  0, 0, -1, 'hFF, 0, 0, 0, 0, 0);

      tick();
      tick();
      chk_all("reset", 'hFF, 0, 0, 0, 0, 0, 0, 0);
      reset_n = 1'b1;
      tick();

      foreach (tv[i]) begin
         comp_start = tv[i].start;
         search_len = tv[i].len;
         pe_ready   = tv[i].rdy;
         vector_x   = '0;
         vector_y   = '0;
         for (int l = 0; l < NP; l++) pe_out[l*DW +: DW] = (l == tv[i].pb) ? tv[i].db : tv[i].da;
         tick();
         chk_all($sformatf("tv%0d", i), tv[i].e_best, tv[i].e_pe, 0, 0, tv[i].e_cnt, tv[i].e_busy, tv[i].e_done, tv[i].e_rv);
      end

      // equal distortions: bias picks the smaller |x|+|y|, otherwise the earlier candidate stays
      comp_start = 1'b1; search_len = 2; pe_ready = '0;
      tick();
      pe_ready = 16'h0004; set_lane(2, 20, 4'd3, 4'hE);
      tick();
      pe_ready = 16'h0020; set_lane(5, 20, 4'd0, 4'd1);
      tick();
      if (BIAS) chk_all("tie", 20, 5, 4'd0, 4'd1, 2, 0, 1, 1);
      else      chk_all("tie", 20, 2, 4'd3, 4'hE, 2, 0, 1, 1);
      comp_start = 1'b0; pe_ready = '0;
      tick();

      comp_start = 1'b1; search_len = 5;
      tick();
      pe_ready = 16'h0002; set_lane(1, 7, 4'd1, 4'd2);
      tick();
      chk_all("pre_rst", 7, 1, 4'd1, 4'd2, 1, 1, 0, 0);
      pe_ready = '0;
      #2 reset_n = 1'b0;
      #1 chk_all("async_rst", 'hFF, 0, 0, 0, 0, 0, 0, 0);
      comp_start = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      chk_all("post_rst", 'hFF, 0, 0, 0, 0, 0, 0, 0);

      for (int s = 0; s < 40; s++) begin
         len = $urandom_range(0, 24);
         comp_start = 1'b1;
         search_len = CW'(len);
         randomize_lanes();
         tick();
         q.delete();
         cnt = 0;
         chk_all($sformatf("r%0d.start", s), 'hFF, 0, 0, 0, 0, 1, 0, 0);
         fin = 1'b0;
         cyc = 0;
         while (!fin && cyc < 100) begin
            randomize_lanes();
            tick();
            if (len == 0) fin = 1'b1;
            else begin
               for (int l = 0; l < NP; l++)
                  if (pe_ready[l]) begin
                     q.push_back('{int'(pe_out[l*DW +: DW]), l, vector_x[l*VW +: VW], vector_y[l*VW +: VW],
                                   mg(vector_x[l*VW +: VW]) + mg(vector_y[l*VW +: VW])});
                     cnt = cnt < 1023 ? cnt + 1 : 1023;
                  end
               fin = cnt >= len;
            end
            b = '{255, 0, '0, '0, 0};
            foreach (q[j]) if (q[j].d < b.d || (BIAS && q[j].d == b.d && q[j].m < b.m)) b = q[j];
            chk_all($sformatf("r%0d.c%0d", s, cyc), b.d, b.pe, b.x, b.y, cnt, !fin, fin, fin);
            cyc++;
         end
         if (!fin) chk("random_search_bound", 0, 1);
         comp_start = 1'b0;
         tick();
         chk($sformatf("r%0d.idle_rv", s), 32'(result_valid), 0);
         chk($sformatf("r%0d.idle_busy", s), 32'(busy), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
